// File: rtl/ha_array_pkg.sv
// rtl/ha_array_pkg.sv - shared widths and FSM state type for the row accumulator
package ha_array_pkg;

    localparam int ROWS  = 4;
    localparam int B_W   = 7;
    localparam int T_W   = 9;
    localparam int ROW_W = 10;
    localparam int ACC_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ha_row_value.sv
// rtl/ha_row_value.sv - weighted value of one partial-product row (sum row plus shifted carry row)
module ha_row_value
    import ha_array_pkg::*;
(
    input  logic [B_W-1:0]   b_i,
    input  logic [T_W-1:0]   t_i,
    output logic [ROW_W-1:0] v_o
);

    // Carry bits 0..5 weigh one place up; carry bit 6 lands on the sum row's top bit.
    assign v_o = ROW_W'(t_i)
               + ROW_W'({b_i[5:0], 1'b0})
               + ROW_W'({b_i[6], 8'b0});

endmodule

// File: rtl/ha_array_accumulator.sv
// rtl/ha_array_accumulator.sv - captures four partial-product rows and sums them one row per cycle
module ha_array_accumulator
    import ha_array_pkg::*;
#(
    parameter int SATURATE = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [B_W-1:0] ha_array_0_b,
    input  logic [B_W-1:0] ha_array_1_b,
    input  logic [B_W-1:0] ha_array_2_b,
    input  logic [B_W-1:0] ha_array_3_b,
    input  logic [T_W-1:0] ha_array_0_t,
    input  logic [T_W-1:0] ha_array_1_t,
    input  logic [T_W-1:0] ha_array_2_t,
    input  logic [T_W-1:0] ha_array_3_t,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [15:0]    product,
    output logic           ovf
);

    state_t                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [ROWS-1:0][B_W-1:0]   b_q, b_d;
    logic [ROWS-1:0][T_W-1:0]   t_q, t_d;
    logic [ROW_W-1:0]           row_v;

    ha_row_value u_row_value (
        .b_i (b_q[cnt_q]),
        .t_i (t_q[cnt_q]),
        .v_o (row_v)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        t_d     = t_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    b_d     = {ha_array_3_b, ha_array_2_b, ha_array_1_b, ha_array_0_b};
                    t_d     = {ha_array_3_t, ha_array_2_t, ha_array_1_t, ha_array_0_t};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_d = acc_q + (ACC_W'(row_v) << {cnt_q, 1'b0});
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(ROWS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            t_q     <= t_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign ovf       = acc_q[ACC_W-1];
    assign product   = (ovf && (SATURATE != 0)) ? 16'hFFFF : acc_q[15:0];

endmodule

// File: tb/tb_ha_array_accumulator.sv
// tb/tb_ha_array_accumulator.sv - table-driven scoreboard bench for both saturate and wrap builds
module tb_ha_array_accumulator;

    typedef struct packed {
        logic [3:0][6:0] b;
        logic [3:0][8:0] t;
        logic [15:0]     exp_sat;
        logic [15:0]     exp_wrap;
        logic            exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] sat;
        logic [15:0] wrap;
        logic        ovf;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0][6:0] cur_b;
    logic [3:0][8:0] cur_t;
    logic            in_valid;
    logic            out_ready;
    logic            in_ready_s, out_valid_s, ovf_s;
    logic            in_ready_w, out_valid_w, ovf_w;
    logic [15:0]     product_s, product_w;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    vec_t tbl[10];

    always #5 clk = ~clk;

    ha_array_accumulator #(.SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst),
        .ha_array_0_b(cur_b[0]), .ha_array_1_b(cur_b[1]),
        .ha_array_2_b(cur_b[2]), .ha_array_3_b(cur_b[3]),
        .ha_array_0_t(cur_t[0]), .ha_array_1_t(cur_t[1]),
        .ha_array_2_t(cur_t[2]), .ha_array_3_t(cur_t[3]),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .product(product_s), .ovf(ovf_s)
    );

    ha_array_accumulator #(.SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst),
        .ha_array_0_b(cur_b[0]), .ha_array_1_b(cur_b[1]),
        .ha_array_2_b(cur_b[2]), .ha_array_3_b(cur_b[3]),
        .ha_array_0_t(cur_t[0]), .ha_array_1_t(cur_t[1]),
        .ha_array_2_t(cur_t[2]), .ha_array_3_t(cur_t[3]),
        .in_valid(in_valid), .in_ready(in_ready_w),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .product(product_w), .ovf(ovf_w)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Bit-level reference: each bit contributes its weight directly.
    function automatic int model_sum(input logic [3:0][6:0] b, input logic [3:0][8:0] t);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 9; i++) if (t[k][i]) s += (1 << (i + 2 * k));
            for (int i = 0; i < 6; i++) if (b[k][i]) s += (1 << (i + 1 + 2 * k));
            if (b[k][6]) s += (1 << (8 + 2 * k));
        end
        return s;
    endfunction

    function automatic vec_t mk(input logic [3:0][6:0] b, input logic [3:0][8:0] t);
        vec_t v;
        int   s = model_sum(b, t);
        v.b        = b;
        v.t        = t;
        v.exp_ovf  = (s > 65535);
        v.exp_wrap = 16'(s);
        v.exp_sat  = v.exp_ovf ? 16'hFFFF : 16'(s);
        return v;
    endfunction

    function automatic vec_t mk_const(input logic [3:0][6:0] b, input logic [3:0][8:0] t,
                                      input logic [15:0] es, input logic [15:0] ew, input logic eo);
        vec_t v;
        v.b = b; v.t = t; v.exp_sat = es; v.exp_wrap = ew; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input bit toggle, input bit early_ready, input int hold);
        int   lat;
        exp_t e;
        logic [15:0] p0;
        cur_b    = v.b;
        cur_t    = v.t;
        in_valid = 1'b1;
        check("in_ready_idle", int'(in_ready_s), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.sat = v.exp_sat; e.wrap = v.exp_wrap; e.ovf = v.exp_ovf;
        sb_q.push_back(e);
        if (early_ready) out_ready = 1'b1;
        lat = 0;
        while (!out_valid_s && lat < 20) begin
            if (toggle) begin
                for (int k = 0; k < 4; k++) begin
                    cur_b[k] = 7'($urandom);
                    cur_t[k] = 9'($urandom);
                end
            end
            check("in_ready_busy", int'(in_ready_s), 0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 4);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("product_sat", int'(product_s), int'(e.sat));
            check("product_wrap", int'(product_w), int'(e.wrap));
            check("ovf_sat", int'(ovf_s), int'(e.ovf));
            check("ovf_wrap", int'(ovf_w), int'(e.ovf));
        end
        check("in_ready_done", int'(in_ready_s), 0);
        p0 = product_s;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("hold_valid", int'(out_valid_s), 1);
            check("hold_product", int'(product_s), int'(p0));
            check("hold_in_ready", int'(in_ready_s), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", int'(out_valid_s), 0);
        check("release_in_ready", int'(in_ready_s), 1);
    endtask

    initial begin
        logic [3:0][6:0] zb;
        logic [3:0][8:0] zt;
        logic [3:0][6:0] fb;
        logic [3:0][8:0] ft;
        logic [3:0][6:0] rb;
        logic [3:0][8:0] rt;

        zb = '0; zt = '0;
        fb = '1; ft = '1;
        tbl[0] = mk_const(zb, zt, 16'd0, 16'd0, 1'b0);
        zt[0][0] = 1'b1;
        tbl[1] = mk_const(zb, zt, 16'd1, 16'd1, 1'b0);
        zt = '0; zb[3][6] = 1'b1;
        tbl[2] = mk_const(zb, zt, 16'd16384, 16'd16384, 1'b0);
        zb = '0; zb[1][0] = 1'b1;
        tbl[3] = mk_const(zb, zt, 16'd8, 16'd8, 1'b0);
        tbl[4] = mk_const(fb, ft, 16'hFFFF, 16'h2881, 1'b1);
        zb = '0; zt = '0; zt[0] = 9'h1FF;
        tbl[5] = mk_const(zb, zt, 16'd511, 16'd511, 1'b0);
        for (int i = 6; i < 10; i++) begin
            for (int k = 0; k < 4; k++) begin
                rb[k] = 7'($urandom);
                rt[k] = 9'($urandom);
            end
            tbl[i] = mk(rb, rt);
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cur_b = '0; cur_t = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready_s), 1);
        check("rst_out_valid", int'(out_valid_s), 0);
        check("rst_product", int'(product_s), 0);
        check("rst_ovf", int'(ovf_s), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_op(tbl[i], 1'b0, 1'b0, 0);

        run_op(tbl[4], 1'b0, 1'b0, 10);
        run_op(tbl[7], 1'b1, 1'b0, 0);
        run_op(tbl[8], 1'b1, 1'b1, 0);

        // Abort mid-accumulation, then confirm a clean restart.
        cur_b = tbl[4].b; cur_t = tbl[4].t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        check("abort_out_valid", int'(out_valid_s), 0);
        check("abort_in_ready", int'(in_ready_s), 1);
        check("abort_product", int'(product_s), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(tbl[5], 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ha_array_accumulator.md
HA_ARRAY_ACCUMULATOR -- requirements
Module: ha_array_accumulator

Interface
REQ-001 SHALL have parameter SATURATE, default 1, meaning: 1 clamps the result to 16'hFFFF on overflow; 0 keeps the low 16 bits (wrap).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports ha_array_k_b  input  7  carry-row vector of partial-product row k, for k = 0..3.
REQ-005 SHALL have ports ha_array_k_t  input  9  sum-row vector of partial-product row k, for k = 0..3.
REQ-006 SHALL have port in_valid  input  1  the eight row vectors are valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a row set this cycle.
REQ-008 SHALL have port out_valid  output  1  product and ovf are valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port product  output  16  accumulated product.
REQ-011 SHALL have port ovf  output  1  the 17-bit sum exceeded 16'hFFFF.

Function
REQ-012 Row value SHALL be V_k = sum over i=0..8 of t[i]*2^i, plus sum over i=0..5 of b[i]*2^(i+1), plus b[6]*2^8; V_k is 10 bits wide, with a maximum of 893.
REQ-013 Total SHALL be S = sum over k=0..3 of V_k*2^(2k), held in a 17-bit accumulator; the maximum is 75905, so no 17-bit wrap occurs.
REQ-014 FSM states SHALL be IDLE, ACC and DONE.
REQ-015 IDLE: in_ready=1 and out_valid=0. When in_valid=1, all eight vectors are registered, the accumulator is cleared, the row counter is set to 0, and the state becomes ACC.
REQ-016 ACC: in_ready=0 and out_valid=0. Each cycle adds V_cnt<<(2*cnt) to the accumulator and increments cnt. The edge that processes cnt=3 moves the state to DONE.
REQ-017 Latency SHALL be: out_valid is first high 4 cycles after the accepting edge; minimum initiation interval is 6 cycles.
REQ-018 DONE: out_valid=1 and in_ready=0.
REQ-019 ovf SHALL be accumulator bit 16.
REQ-020 product SHALL be 16'hFFFF when ovf=1 and SATURATE=1; otherwise it is accumulator[15:0].
REQ-021 DONE with out_ready=1 SHALL transition to IDLE.
REQ-022 While out_ready=0, product and ovf SHALL hold stable.
REQ-023 Input vectors SHALL be ignored outside the accepting cycle; changes to them during ACC or DONE SHALL NOT affect the result.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 While rst=1, regardless of clk: state=IDLE, cnt=0, accumulator=0, registered vectors=0, in_ready=1, out_valid=0, product=0, ovf=0.
REQ-026 Reset asserted during ACC or DONE SHALL discard the operation in progress with no partial output.
REQ-027 After reset deasserts, the first edge with in_valid=1 SHALL be accepted.

Structure
REQ-028 Shared package ha_array_pkg SHALL hold: ROWS=4, B_W=7, T_W=9, ROW_W=10, ACC_W=17, and the FSM state enum.
REQ-029 One combinational sub-module, ha_row_value, SHALL compute V_k from (b, t); a single instance is muxed by cnt.

Verification
REQ-030 All row inputs 0 -> out_valid after 4 cycles, product=0, ovf=0.
REQ-031 Only ha_array_0_t[0]=1 -> product=1. Only ha_array_3_b[6]=1 -> product=16384 (2^14). Only ha_array_1_b[0]=1 -> product=8.
REQ-032 All b and t bits 1 in every row -> S=75905, ovf=1. With SATURATE=1, product=16'hFFFF; with SATURATE=0, product=16'h2881.
REQ-033 out_ready held 0 for 10 cycles in DONE -> product and out_valid stable and in_ready=0; out_ready=1 -> IDLE on the next edge and in_ready=1.
REQ-034 rst pulsed during ACC (cnt=2) -> out_valid=0 and in_ready=1 immediately; the next operation (row 0 t=9'h1FF only) gives product=511.
REQ-035 Input vectors toggled randomly during ACC -> product equals the value computed from the vectors captured at acceptance.
